boss_ctrl: RTL and testbench



---
 rtl/boss_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_boss_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/boss_ctrl.sv
// Stage-3 boss sequencer: per-frame behaviour FSM driving the boss
// sprite position, animation column, hit points, fire request and death flag.
module boss_ctrl #(
    parameter int STAGE3        = 6,
    parameter int X_MIN         = 10,
    parameter int X_MAX         = 300,
    parameter int Y_HOME        = 30,
    parameter int X_START       = 155,
    parameter int SPEED         = 2,
    parameter int ANIM_DIV      = 8,
    parameter int PATROL_FRAMES = 120,
    parameter int ATTACK_FRAMES = 30,
    parameter int HURT_FRAMES   = 20,
    parameter int HP_INIT       = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic       frame_tick,
    input  logic       hit,
    output logic [8:0] boss_x,
    output logic [8:0] boss_y,
    output logic [3:0] boss_state,
    output logic [3:0] boss_hp,
    output logic       fire,
    output logic       boss_dead
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ENTER  = 3'd1;
    localparam logic [2:0] S_PATROL = 3'd2;
    localparam logic [2:0] S_ATTACK = 3'd3;
    localparam logic [2:0] S_HURT   = 3'd4;
    localparam logic [2:0] S_DEAD   = 3'd5;

    logic [2:0] fsm, fsm_n;
    logic [8:0] x_n, y_n;
    logic [3:0] bs_n, hp_n;
    logic       fire_n, dead_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] anim, anim_n;
    logic       dir_left, dir_left_n;

    logic       in_stage;
    logic       take_hit;
    logic       anim_wrap;
    logic [3:0] bs_step;
    logic [9:0] x_right;
    logic [8:0] x_left;

    assign in_stage  = (state == 4'(STAGE3));
    assign take_hit  = hit && (fsm == S_PATROL || fsm == S_ATTACK);
    assign anim_wrap = (anim == 8'(ANIM_DIV - 1));
    assign bs_step   = {2'b00, boss_state[1:0] + 2'd1};
    assign x_right   = {1'b0, boss_x} + 10'(SPEED);
    assign x_left    = boss_x - 9'(SPEED);

    // Next-state and next-output selection for the boss behaviour FSM
    always_comb begin
        fsm_n      = fsm;
        x_n        = boss_x;
        y_n        = boss_y;
        bs_n       = boss_state;
        hp_n       = boss_hp;
        fire_n     = 1'b0;
        dead_n     = boss_dead;
        cnt_n      = cnt;
        anim_n     = anim;
        dir_left_n = dir_left;

        if (fsm != S_IDLE && !in_stage) begin
            fsm_n      = S_IDLE;
            x_n        = 9'(X_START);
            y_n        = 9'd0;
            bs_n       = 4'd0;
            hp_n       = 4'(HP_INIT);
            dead_n     = 1'b0;
            cnt_n      = 8'd0;
            anim_n     = 8'd0;
            dir_left_n = 1'b0;
        end else if (take_hit) begin
            if (boss_hp == 4'd1) begin
                hp_n   = 4'd0;
                fsm_n  = S_DEAD;
                dead_n = 1'b1;
                bs_n   = 4'd6;
            end else begin
                hp_n  = boss_hp - 4'd1;
                fsm_n = S_HURT;
                cnt_n = 8'd0;
                bs_n  = 4'd5;
            end
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (in_stage)
                        fsm_n = S_ENTER;
                end
                S_ENTER: begin
                    if (frame_tick) begin
                        y_n = boss_y + 9'd1;
                        if (anim_wrap) begin
                            anim_n = 8'd0;
                            bs_n   = bs_step;
                        end else begin
                            anim_n = anim + 8'd1;
                        end
                        if (boss_y + 9'd1 == 9'(Y_HOME)) begin
                            fsm_n      = S_PATROL;
                            cnt_n      = 8'd0;
                            dir_left_n = 1'b0;
                            anim_n     = 8'd0;
                            bs_n       = 4'd0;
                        end
                    end
                end
                S_PATROL: begin
                    if (frame_tick) begin
                        if (!dir_left) begin
                            if (x_right > 10'(X_MAX)) begin
                                x_n        = 9'(X_MAX);
                                dir_left_n = 1'b1;
                            end else begin
                                x_n = x_right[8:0];
                            end
                        end else begin
                            if ({1'b0, boss_x} < 10'(X_MIN + SPEED)) begin
                                x_n        = 9'(X_MIN);
                                dir_left_n = 1'b0;
                            end else begin
                                x_n = x_left;
                            end
                        end
                        if (anim_wrap) begin
                            anim_n = 8'd0;
                            bs_n   = bs_step;
                        end else begin
                            anim_n = anim + 8'd1;
                        end
                        if (cnt == 8'(PATROL_FRAMES - 1)) begin
                            fsm_n  = S_ATTACK;
                            cnt_n  = 8'd0;
                            fire_n = 1'b1;
                            bs_n   = 4'd4;
                        end else begin
                            cnt_n = cnt + 8'd1;
                        end
                    end
                end
                S_ATTACK: begin
                    if (frame_tick) begin
                        if (cnt == 8'(ATTACK_FRAMES - 1)) begin
                            fsm_n  = S_PATROL;
                            cnt_n  = 8'd0;
                            anim_n = 8'd0;
                            bs_n   = 4'd0;
                        end else begin
                            cnt_n = cnt + 8'd1;
                        end
                    end
                end
                S_HURT: begin
                    if (frame_tick) begin
                        if (cnt == 8'(HURT_FRAMES - 1)) begin
                            fsm_n  = S_PATROL;
                            cnt_n  = 8'd0;
                            anim_n = 8'd0;
                            bs_n   = 4'd0;
                        end else begin
                            cnt_n = cnt + 8'd1;
                            bs_n  = (boss_state == 4'd5) ? 4'd0 : 4'd5;
                        end
                    end
                end
                S_DEAD: begin
                end
                default: begin
                    fsm_n = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset drops the boss back to its spawn values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= S_IDLE;
            boss_x     <= 9'(X_START);
            boss_y     <= 9'd0;
            boss_state <= 4'd0;
            boss_hp    <= 4'(HP_INIT);
            fire       <= 1'b0;
            boss_dead  <= 1'b0;
            cnt        <= 8'd0;
            anim       <= 8'd0;
            dir_left   <= 1'b0;
        end else begin
            fsm        <= fsm_n;
            boss_x     <= x_n;
            boss_y     <= y_n;
            boss_state <= bs_n;
            boss_hp    <= hp_n;
            fire       <= fire_n;
            boss_dead  <= dead_n;
            cnt        <= cnt_n;
            anim       <= anim_n;
            dir_left   <= dir_left_n;
        end
    end

endmodule

// File: tb/tb_boss_ctrl.sv
// Randomised bench for boss_ctrl against a behavioural model of the
// boss: phases, tick counts and positions tracked with plain integers.
module tb_boss_ctrl;

    localparam int STAGE3 = 6;
    localparam int P_IDLE = 0, P_ENTER = 1, P_PATROL = 2;
    localparam int P_ATTACK = 3, P_HURT = 4, P_DEAD = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] state = 4'd0;
    logic       frame_tick = 1'b0;
    logic       hit = 1'b0;
    logic [8:0] boss_x, boss_y;
    logic [3:0] boss_state, boss_hp;
    logic       fire, boss_dead;

    boss_ctrl dut (
        .clk(clk), .rst(rst), .state(state),
        .frame_tick(frame_tick), .hit(hit),
        .boss_x(boss_x), .boss_y(boss_y),
        .boss_state(boss_state), .boss_hp(boss_hp),
        .fire(fire), .boss_dead(boss_dead)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cc = 0;

    int mphase, mx, my, mhp, mdir, mcnt, manim, mflash, mfire;

    task automatic chk(input string tag, input int obs, input int want);
        nvec++;
        if (obs !== want) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, want, $time);
        end
    endtask

    task automatic model_reset();
        mphase = P_IDLE; mx = 155; my = 0; mhp = 10; mdir = 1;
        mcnt = 0; manim = 0; mflash = 0; mfire = 0;
    endtask

    function automatic int exp_bs();
        case (mphase)
            P_ENTER, P_PATROL: return (manim / 8) % 4;
            P_ATTACK: return 4;
            P_HURT: return mflash ? 5 : 0;
            P_DEAD: return 6;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input int st, input int tk, input int ht);
        mfire = 0;
        if (mphase != P_IDLE && st != STAGE3) begin
            model_reset();
            return;
        end
        if (ht != 0 && (mphase == P_PATROL || mphase == P_ATTACK)) begin
            if (mhp == 1) begin
                mhp = 0; mphase = P_DEAD;
            end else begin
                mhp--; mphase = P_HURT; mcnt = 0; mflash = 1;
            end
            return;
        end
        case (mphase)
            P_IDLE: if (st == STAGE3) mphase = P_ENTER;
            P_ENTER: if (tk != 0) begin
                my++; manim++;
                if (my == 30) begin
                    mphase = P_PATROL; mcnt = 0; mdir = 1; manim = 0;
                end
            end
            P_PATROL: if (tk != 0) begin
                if (mx + 2 * mdir > 300) begin mx = 300; mdir = -1; end
                else if (mx + 2 * mdir < 10) begin mx = 10; mdir = 1; end
                else mx = mx + 2 * mdir;
                manim++; mcnt++;
                if (mcnt == 120) begin
                    mphase = P_ATTACK; mcnt = 0; mfire = 1;
                end
            end
            P_ATTACK: if (tk != 0) begin
                mcnt++;
                if (mcnt == 30) begin
                    mphase = P_PATROL; mcnt = 0; manim = 0;
                end
            end
            P_HURT: if (tk != 0) begin
                mcnt++;
                if (mcnt == 20) begin
                    mphase = P_PATROL; mcnt = 0; manim = 0;
                end else begin
                    mflash = !mflash;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x"}, int'(boss_x), mx);
        chk({tag, ".y"}, int'(boss_y), my);
        chk({tag, ".anim"}, int'(boss_state), exp_bs());
        chk({tag, ".hp"}, int'(boss_hp), mhp);
        chk({tag, ".fire"}, int'(fire), mfire);
        chk({tag, ".dead"}, int'(boss_dead), (mphase == P_DEAD) ? 1 : 0);
    endtask

    task automatic cyc(input string tag, input logic [3:0] st,
                       input logic tk, input logic ht);
        @(negedge clk);
        state = st; frame_tick = tk; hit = ht;
        @(posedge clk);
        model_step(int'(st), int'(tk), int'(ht));
        #1 check_all(tag);
    endtask

    function automatic logic reg_tick();
        cc++;
        return (cc % 4 == 0);
    endfunction

    task automatic run_to(input string tag, input int ph, input int cnt_want,
                          input int budget);
        int g = 0;
        while (!(mphase == ph && (cnt_want < 0 || mcnt == cnt_want))
               && g < budget) begin
            cyc(tag, 4'(STAGE3), reg_tick(), 1'b0);
            g++;
        end
        if (g >= budget)
            chk({tag, ".timeout"}, 0, 1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        for (int i = 0; i < 2400; i++)
            cyc("sweep", 4'(STAGE3), reg_tick(), 1'b0);

        for (int i = 0; i < 20000; i++) begin
            logic [3:0] st;
            st = ($urandom_range(0, 1499) == 0) ? 4'd2 : 4'(STAGE3);
            cyc("rand", st, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 149) == 0));
        end

        cyc("leave", 4'd0, 1'b0, 1'b0);
        run_to("to_attack_edge", P_PATROL, 119, 3000);
        cyc("hit_at_attack", 4'(STAGE3), 1'b1, 1'b1);
        chk("hit_at_attack.no_fire", int'(fire), 0);

        for (int k = 0; k < 12 && mphase != P_DEAD; k++) begin
            run_to("to_patrol", P_PATROL, -1, 500);
            cyc("kill", 4'(STAGE3), 1'b0, 1'b1);
        end
        chk("dead_reached", (mphase == P_DEAD) ? 1 : 0, 1);
        for (int i = 0; i < 40; i++)
            cyc("dead_hold", 4'(STAGE3), reg_tick(), ($urandom_range(0, 3) == 0));

        cyc("leave2", 4'd0, 1'b0, 1'b0);
        run_to("to_attack", P_ATTACK, 5, 3000);
        cyc("mid_attack_exit", 4'd2, 1'b1, 1'b0);
        chk("exit.idle_hp", int'(boss_hp), 10);

        run_to("to_patrol2", P_PATROL, 10, 1500);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        state = 4'd0; frame_tick = 1'b0; hit = 1'b0;
        rst = 1'b0;
        cyc("post_rst", 4'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
